bytes_to_bits_sched: RTL and testbench



---
 rtl/kyber_b2b_pkg.sv | 20 ++
 rtl/bytes_to_bits_sched_if.sv | 31 +++
 rtl/b2b_rr_arbiter.sv | 24 ++
 rtl/bytes_to_bits_sched.sv | 109 ++++++++++
 tb/tb_bytes_to_bits_sched.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/kyber_b2b_pkg.sv
// Shared types and sizes for the bytes_to_bits scheduler slice.
package kyber_b2b_pkg;

   localparam int NUM_REQ    = 2;
   localparam int BYTE_COUNT = 128;
   localparam int BIT_COUNT  = BYTE_COUNT * 8;
   localparam int LEN_W      = $clog2(BYTE_COUNT) + 1;

   typedef logic [LEN_W-1:0]              len_t;
   typedef logic [BIT_COUNT-1:0]          bits_t;
   typedef logic [BYTE_COUNT-1:0][7:0]    byte_arr_t;

   typedef enum logic [1:0] {IDLE, LOAD, CONV, HOLD} b2b_state_e;

   // A request longer than the buffer is truncated to the buffer depth.
   function automatic len_t clamp_len(input len_t len);
      return (len > LEN_W'(BYTE_COUNT)) ? LEN_W'(BYTE_COUNT) : len;
   endfunction

endpackage

// File: rtl/bytes_to_bits_sched_if.sv
// Bundle of requester, converter and consumer signals around the scheduler.
interface bytes_to_bits_sched_if
   import kyber_b2b_pkg::*;
();

   logic [NUM_REQ-1:0]       req;
   len_t [NUM_REQ-1:0]       req_len;
   logic [NUM_REQ-1:0]       gnt;
   logic [NUM_REQ-1:0]       in_valid;
   logic [NUM_REQ-1:0][7:0]  in_data;
   logic [NUM_REQ-1:0]       in_ready;
   logic                     cv_enable;
   byte_arr_t                cv_B;
   len_t                     cv_len;
   bits_t                    cv_b;
   logic                     out_valid;
   logic                     out_id;
   bits_t                    out_bits;
   logic                     out_ready;

   modport slave (
      input  req, req_len, in_valid, in_data, cv_b, out_ready,
      output gnt, in_ready, cv_enable, cv_B, cv_len, out_valid, out_id, out_bits
   );

   modport master (
      output req, req_len, in_valid, in_data, cv_b, out_ready,
      input  gnt, in_ready, cv_enable, cv_B, cv_len, out_valid, out_id, out_bits
   );

endinterface

// File: rtl/b2b_rr_arbiter.sv
// Two-way round-robin arbiter; rr_i names the requester favoured on a tie.
module b2b_rr_arbiter
   import kyber_b2b_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               rr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic               idx_o
);

   always_comb begin
      // NOTE: every output gets a default first so no path through the block infers a latch.
      idx_o = 1'b0;
      gnt_o = '0;
      unique case (req_i)
         2'b10:   idx_o = 1'b1;
         2'b11:   idx_o = rr_i;
         default: idx_o = 1'b0;
      endcase
      if (en_i && (|req_i)) gnt_o = idx_o ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/bytes_to_bits_sched.sv
// Time-shares one bytes_to_bits converter between two byte producers:
// arbitrate, buffer the granted job, pulse the converter, hold the result.
module bytes_to_bits_sched
   import kyber_b2b_pkg::*;
(
   input logic                  clk,
   input logic                  rst_n,
   bytes_to_bits_sched_if.slave bus
);

   b2b_state_e         state_q;
   logic               id_q;
   logic               rr_q;
   len_t               len_q;
   len_t               cnt_q;
   logic [NUM_REQ-1:0] gnt_q;
   logic               out_valid_q;
   logic               out_id_q;
   bits_t              out_bits_q;
   byte_arr_t          buf_q;

   logic [NUM_REQ-1:0] arb_gnt;
   logic               arb_idx;
   len_t               len_d;
   len_t               cnt_d;
   logic               take;
   logic               grant;

   b2b_rr_arbiter u_arb (
      .req_i (bus.req),
      .rr_i  (rr_q),
      .en_i  (state_q == IDLE),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   assign grant = |arb_gnt;
   assign len_d = clamp_len(bus.req_len[arb_idx]);
   assign take  = (state_q == LOAD) && bus.in_valid[id_q];
   assign cnt_d = cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         id_q        <= 1'b0;
         rr_q        <= 1'b0;
         len_q       <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_id_q    <= 1'b0;
         out_bits_q  <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         unique case (state_q)
            IDLE: if (grant) begin
               id_q    <= arb_idx;
               len_q   <= len_d;
               cnt_q   <= '0;
               gnt_q   <= arb_gnt;
               state_q <= (len_d != '0) ? LOAD : CONV;
            end
            LOAD: if (take) begin
               cnt_q <= cnt_d;
               if (cnt_d == len_q) state_q <= CONV;
            end
            CONV: begin
               out_bits_q  <= bus.cv_b;
               out_id_q    <= id_q;
               out_valid_q <= 1'b1;
               state_q     <= HOLD;
            end
            HOLD: if (bus.out_ready) begin
               out_valid_q <= 1'b0;
               gnt_q       <= '0;
               rr_q        <= ~id_q;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Clearing the whole buffer at grant is what keeps bytes at index >= len zero.
   always_ff @(posedge clk) begin
      // NOTE: the buffer is reset explicitly so an aborted job can never leak bytes into cv_B.
      if (!rst_n || (state_q == IDLE && grant)) begin
         buf_q <= '0;
      end else begin
         for (int i = 0; i < BYTE_COUNT; i++) begin
            if (take && cnt_q == LEN_W'(i)) buf_q[i] <= bus.in_data[id_q];
         end
      end
   end

   always_comb begin
      bus.in_ready = '0;
      if (state_q == LOAD) bus.in_ready[id_q] = 1'b1;
   end

   assign bus.gnt       = gnt_q;
   assign bus.cv_enable = (state_q == CONV);
   assign bus.cv_B      = buf_q;
   assign bus.cv_len    = (state_q == IDLE) ? '0 : len_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_id    = out_id_q;
   assign bus.out_bits  = out_bits_q;

endmodule

// File: tb/tb_bytes_to_bits_sched.sv
// Directed bench for bytes_to_bits_sched with a behavioural converter beside it.
module tb_bytes_to_bits_sched;
   import kyber_b2b_pkg::*;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   bytes_to_bits_sched_if bus ();

   bytes_to_bits_sched dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Converter: byte i bit j lands on bit 8i+j; result only driven while enabled.
   assign bus.cv_b = bus.cv_enable ? bits_t'(bus.cv_B) : '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input bits_t obs, input bits_t exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h (low 128 bits shown, %0d bits differ)",
                tag, obs[127:0], exp[127:0], $countones(obs ^ exp));
      end
   endtask

   task automatic wait_gnt(output int gap);
      gap = 0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (bus.gnt != '0) break;
         gap++;
      end
      check("wait_gnt_bound", bits_t'(bus.gnt != '0), bits_t'(1'b1));
   endtask

   task automatic wait_valid();
      for (int k = 0; k < 50; k++) begin
         tick();
         if (bus.out_valid) break;
      end
      check("wait_valid_bound", bits_t'(bus.out_valid), bits_t'(1'b1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_gnt"},       bits_t'(bus.gnt),       '0);
      check({tag, "_in_ready"},  bits_t'(bus.in_ready),  '0);
      check({tag, "_out_valid"}, bits_t'(bus.out_valid), '0);
      check({tag, "_out_id"},    bits_t'(bus.out_id),    '0);
      check({tag, "_out_bits"},  bus.out_bits,           '0);
      check({tag, "_cv_enable"}, bits_t'(bus.cv_enable), '0);
      check({tag, "_cv_len"},    bits_t'(bus.cv_len),    '0);
      check({tag, "_cv_B"},      bits_t'(bus.cv_B),      '0);
   endtask

   initial begin
      int gap;
      int acc;
      logic [2:0] seq;

      rst_n         = 1'b0;
      bus.req       = '0;
      bus.req_len   = '0;
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      check_reset_outputs("rst");
      rst_n = 1'b1;
      tick();

      // Single job from requester 0: bytes 0x01, 0x80.
      bus.req        = 2'b01;
      bus.req_len[0] = 8'd2;
      tick();
      check("single_gnt",      bits_t'(bus.gnt),      bits_t'(2'b01));
      check("single_in_ready", bits_t'(bus.in_ready), bits_t'(2'b01));
      check("single_cv_len",   bits_t'(bus.cv_len),   bits_t'(8'd2));
      bus.req        = 2'b00;
      bus.in_valid   = 2'b01;
      bus.in_data[0] = 8'h01;
      tick();
      bus.in_data[0] = 8'h80;
      tick();
      bus.in_valid   = 2'b00;
      check("single_cv_enable", bits_t'(bus.cv_enable), bits_t'(1'b1));
      check("single_valid_early", bits_t'(bus.out_valid), bits_t'(1'b0));
      tick();
      check("single_out_valid", bits_t'(bus.out_valid), bits_t'(1'b1));
      check("single_out_bits",  bus.out_bits,           bits_t'(16'h8001));
      check("single_out_id",    bits_t'(bus.out_id),    bits_t'(1'b0));
      check("single_cv_enable_off", bits_t'(bus.cv_enable), bits_t'(1'b0));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("single_idle_valid",  bits_t'(bus.out_valid), bits_t'(1'b0));
      check("single_idle_gnt",    bits_t'(bus.gnt),       bits_t'(2'b00));
      check("single_idle_cv_len", bits_t'(bus.cv_len),    bits_t'(8'd0));

      // Zero-length job from requester 1.
      bus.req        = 2'b10;
      bus.req_len[1] = 8'd0;
      tick();
      bus.req = 2'b00;
      check("zero_gnt",       bits_t'(bus.gnt),       bits_t'(2'b10));
      check("zero_in_ready",  bits_t'(bus.in_ready),  bits_t'(2'b00));
      check("zero_cv_enable", bits_t'(bus.cv_enable), bits_t'(1'b1));
      tick();
      check("zero_out_valid", bits_t'(bus.out_valid), bits_t'(1'b1));
      check("zero_out_bits",  bus.out_bits,           '0);
      check("zero_out_id",    bits_t'(bus.out_id),    bits_t'(1'b1));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;

      // Contention: both requesting, one byte each; expected grant order 0, 1, 0.
      seq            = 3'b010;
      bus.req        = 2'b11;
      bus.req_len[0] = 8'd1;
      bus.req_len[1] = 8'd1;
      bus.in_valid   = 2'b11;
      bus.in_data[0] = 8'h11;
      bus.in_data[1] = 8'h22;
      bus.out_ready  = 1'b1;
      for (int j = 0; j < 3; j++) begin
         wait_gnt(gap);
         check("cont_gnt", bits_t'(bus.gnt), seq[j] ? bits_t'(2'b10) : bits_t'(2'b01));
         if (j > 0) check("cont_gap", bits_t'(gap), bits_t'(1));
         wait_valid();
         check("cont_out_id", bits_t'(bus.out_id), bits_t'(seq[j]));
         check("cont_out_bits", bus.out_bits, seq[j] ? bits_t'(8'h22) : bits_t'(8'h11));
         if (j == 2) bus.req = 2'b00;
      end
      tick();
      bus.out_ready = 1'b0;
      bus.in_valid  = 2'b00;
      check("cont_end_gnt", bits_t'(bus.gnt), bits_t'(2'b00));

      // Clamp: request the field maximum with 0xFF bytes; only BYTE_COUNT are taken.
      bus.req        = 2'b01;
      bus.req_len[0] = 8'hFF;
      bus.in_valid   = 2'b01;
      bus.in_data[0] = 8'hFF;
      tick();
      bus.req = 2'b00;
      check("clamp_gnt", bits_t'(bus.gnt), bits_t'(2'b01));
      acc = 0;
      for (int k = 0; k < 300; k++) begin
         if (bus.cv_enable) break;
         if (bus.in_ready[0] && bus.in_valid[0]) acc++;
         tick();
      end
      bus.in_valid = 2'b00;
      check("clamp_count",     bits_t'(acc),           bits_t'(BYTE_COUNT));
      check("clamp_cv_enable", bits_t'(bus.cv_enable), bits_t'(1'b1));
      check("clamp_cv_len",    bits_t'(bus.cv_len),    bits_t'(8'd128));
      tick();
      check("clamp_out_bits",  bus.out_bits,           '1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;

      // Bubble in LOAD and backpressure in HOLD, requester 1.
      bus.req        = 2'b10;
      bus.req_len[1] = 8'd2;
      tick();
      bus.req = 2'b00;
      check("bp_in_ready", bits_t'(bus.in_ready), bits_t'(2'b10));
      bus.in_valid   = 2'b10;
      bus.in_data[1] = 8'h3C;
      tick();
      bus.in_valid   = 2'b00;
      tick();
      check("bp_stretch_cv_enable", bits_t'(bus.cv_enable), bits_t'(1'b0));
      check("bp_stretch_in_ready",  bits_t'(bus.in_ready),  bits_t'(2'b10));
      bus.in_valid   = 2'b10;
      bus.in_data[1] = 8'hC3;
      tick();
      bus.in_valid   = 2'b00;
      check("bp_cv_enable", bits_t'(bus.cv_enable), bits_t'(1'b1));
      tick();
      for (int k = 0; k < 5; k++) begin
         check("bp_hold_valid", bits_t'(bus.out_valid), bits_t'(1'b1));
         check("bp_hold_bits",  bus.out_bits,           bits_t'(16'hC33C));
         tick();
      end
      check("bp_out_id", bits_t'(bus.out_id), bits_t'(1'b1));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("bp_release_valid", bits_t'(bus.out_valid), bits_t'(1'b0));
      tick();
      check("bp_idle_gnt", bits_t'(bus.gnt), bits_t'(2'b00));

      // Reset after 3 of 8 bytes, then a fresh one-byte job.
      bus.req        = 2'b01;
      bus.req_len[0] = 8'd8;
      tick();
      bus.req      = 2'b00;
      bus.in_valid = 2'b01;
      for (int b = 0; b < 3; b++) begin
         bus.in_data[0] = 8'h10 + 8'(b);
         tick();
      end
      check("midrst_in_ready_before", bits_t'(bus.in_ready), bits_t'(2'b01));
      rst_n        = 1'b0;
      bus.in_valid = 2'b00;
      tick();
      check_reset_outputs("midrst");
      rst_n = 1'b1;
      tick();
      bus.req        = 2'b01;
      bus.req_len[0] = 8'd1;
      tick();
      bus.req        = 2'b00;
      bus.in_valid   = 2'b01;
      bus.in_data[0] = 8'hA5;
      tick();
      bus.in_valid   = 2'b00;
      tick();
      check("post_rst_valid", bits_t'(bus.out_valid), bits_t'(1'b1));
      check("post_rst_bits",  bus.out_bits,           bits_t'(8'hA5));
      check("post_rst_id",    bits_t'(bus.out_id),    bits_t'(1'b0));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
